// File: rtl/voice_allocator.sv
// Note-event to voice-register-bus write sequencer: tracks sounding voices,
// picks a target voice (free, retrigger or round-robin steal) and strobes the writes.
module voice_allocator #(
  parameter int VOICES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              NoteValid,
  output logic              NoteReady,
  input  logic              NoteOn,
  input  logic [7:0]        NoteKey,
  input  logic [7:0]        NoteIncr,
  input  logic [7:0]        NoteWave,
  input  logic [7:0]        NotePulse,
  input  logic [7:0]        NoteSustain,
  output logic [15:0]       BusAddress,
  output logic [7:0]        BusWriteData,
  output logic              BusReadWrite,
  output logic              BusClock,
  output logic [VOICES-1:0] VoiceActive,
  output logic              Stolen
);

  localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, DECIDE, STROBE_HI, STROBE_LO} state_t;

  state_t        state;
  logic          cap_on;
  logic [7:0]    cap_key, cap_incr, cap_wave, cap_pulse, cap_sustain;
  logic [7:0]    keys [VOICES];
  logic [PW-1:0] steal_ptr;
  logic [3:0]    voice;
  logic [2:0]    entry, last_entry;

  logic          match_hit, free_hit;
  logic [3:0]    match_idx, free_idx;
  logic [3:0]    tgt;
  logic [2:0]    tgt_first;
  logic          tgt_writes, tgt_steal, tgt_advance;
  logic [3:0]    next_voice;
  logic [2:0]    next_idx;
  logic [3:0]    next_offset;
  logic [15:0]   next_addr;
  logic [7:0]    next_data;

  assign NoteReady = (state == IDLE) && !Reset;

  // Descending scan so the lowest-index match / free voice is the one kept.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (VoiceActive[v] && keys[v] == cap_key) begin
        match_hit = 1'b1;
        match_idx = 4'(v);
      end
      if (!VoiceActive[v]) begin
        free_hit = 1'b1;
        free_idx = 4'(v);
      end
    end
  end

  // Write list is a window into the fixed sequence Gate=0, Incr, Wave, Pulse, Sustain, Gate=1.
  always_comb begin
    tgt         = '0;
    tgt_first   = 3'd1;
    tgt_writes  = 1'b1;
    tgt_steal   = 1'b0;
    tgt_advance = 1'b0;
    if (cap_on) begin
      if (match_hit) begin
        tgt       = match_idx;
        tgt_first = 3'd0;
        tgt_steal = 1'b1;
      end else if (free_hit) begin
        tgt = free_idx;
      end else begin
        tgt         = 4'(steal_ptr);
        tgt_first   = 3'd0;
        tgt_steal   = 1'b1;
        tgt_advance = 1'b1;
      end
    end else begin
      tgt        = match_idx;
      tgt_first  = 3'd0;
      tgt_writes = match_hit;
    end
  end

  always_comb begin
    next_voice  = (state == DECIDE) ? tgt : voice;
    next_idx    = (state == DECIDE) ? tgt_first : entry + 3'd1;
    next_offset = (next_idx == 3'd5) ? 4'd0 : {1'b0, next_idx};
    next_addr   = {8'h00, next_voice + 4'd1, next_offset};
    case (next_idx)
      3'd1:    next_data = cap_incr;
      3'd2:    next_data = cap_wave;
      3'd3:    next_data = cap_pulse;
      3'd4:    next_data = cap_sustain;
      3'd5:    next_data = 8'h01;
      default: next_data = 8'h00;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      cap_on       <= 1'b0;
      cap_key      <= '0;
      cap_incr     <= '0;
      cap_wave     <= '0;
      cap_pulse    <= '0;
      cap_sustain  <= '0;
      for (int v = 0; v < VOICES; v++) keys[v] <= '0;
      steal_ptr    <= '0;
      voice        <= '0;
      entry        <= '0;
      last_entry   <= '0;
      BusAddress   <= '0;
      BusWriteData <= '0;
      BusReadWrite <= 1'b0;
      BusClock     <= 1'b0;
      VoiceActive  <= '0;
      Stolen       <= 1'b0;
    end else begin
      Stolen <= 1'b0;
      case (state)
        IDLE: begin
          if (NoteValid) begin
            cap_on      <= NoteOn;
            cap_key     <= NoteKey;
            cap_incr    <= NoteIncr;
            cap_wave    <= NoteWave;
            cap_pulse   <= NotePulse;
            cap_sustain <= NoteSustain;
            state       <= DECIDE;
          end
        end
        DECIDE: begin
          for (int v = 0; v < VOICES; v++) begin
            if (tgt_writes && tgt == 4'(v)) begin
              VoiceActive[v] <= cap_on;
              if (cap_on) keys[v] <= cap_key;
            end
          end
          if (tgt_advance) steal_ptr <= (steal_ptr == LAST_PTR) ? '0 : steal_ptr + 1'b1;
          Stolen     <= tgt_steal;
          voice      <= tgt;
          entry      <= tgt_first;
          last_entry <= cap_on ? 3'd5 : 3'd0;
          if (tgt_writes) begin
            BusAddress   <= next_addr;
            BusWriteData <= next_data;
            BusReadWrite <= 1'b1;
            BusClock     <= 1'b1;
            state        <= STROBE_HI;
          end else begin
            state <= IDLE;
          end
        end
        STROBE_HI: begin
          BusClock <= 1'b0;
          state    <= STROBE_LO;
        end
        STROBE_LO: begin
          if (entry == last_entry) begin
            BusReadWrite <= 1'b0;
            BusAddress   <= '0;
            BusWriteData <= '0;
            state        <= IDLE;
          end else begin
            entry        <= entry + 3'd1;
            BusAddress   <= next_addr;
            BusWriteData <= next_data;
            BusClock     <= 1'b1;
            state        <= STROBE_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// note traffic compared against a voice-table reference model.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          NoteValid, NoteOn;
  logic [7:0]    NoteKey, NoteIncr, NoteWave, NotePulse, NoteSustain;
  logic          NoteReady;
  logic [15:0]   BusAddress;
  logic [7:0]    BusWriteData;
  logic          BusReadWrite, BusClock, Stolen;
  logic [NV-1:0] VoiceActive;

  voice_allocator #(.VOICES(NV)) dut (
    .Clock(Clock), .Reset(Reset), .NoteValid(NoteValid), .NoteReady(NoteReady),
    .NoteOn(NoteOn), .NoteKey(NoteKey), .NoteIncr(NoteIncr), .NoteWave(NoteWave),
    .NotePulse(NotePulse), .NoteSustain(NoteSustain), .BusAddress(BusAddress),
    .BusWriteData(BusWriteData), .BusReadWrite(BusReadWrite), .BusClock(BusClock),
    .VoiceActive(VoiceActive), .Stolen(Stolen)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a table of sounding voices and a round-robin pointer.
  bit            m_active [NV];
  logic [7:0]    m_key [NV];
  int            m_ptr;
  logic [15:0]   exp_addr [$];
  logic [7:0]    exp_data [$];
  logic          exp_stolen;
  int            exp_cycles;
  logic [NV-1:0] exp_active;

  logic [15:0]   obs_addr [$];
  logic [7:0]    obs_data [$];
  logic          obs_stolen, obs_decide_rw;
  bit            obs_stolen_extra, obs_hold_err;
  int            obs_cycles;
  logic [NV-1:0] obs_active;
  bit            noise = 1'b0;

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_active[v] = 1'b0;
      m_key[v] = 8'h00;
    end
    m_ptr = 0;
  endtask

  task automatic model_event(input bit on, input logic [7:0] key, incr, wave, pulse, sus);
    int hit, free, v;
    logic [15:0] base;
    exp_addr.delete();
    exp_data.delete();
    exp_stolen = 1'b0;
    hit = -1;
    free = -1;
    for (int i = NV - 1; i >= 0; i--) begin
      if (m_active[i] && m_key[i] == key) hit = i;
      if (!m_active[i]) free = i;
    end
    if (on) begin
      if (hit >= 0) begin
        v = hit;
        exp_stolen = 1'b1;
      end else if (free >= 0) begin
        v = free;
      end else begin
        v = m_ptr;
        m_ptr = (m_ptr + 1) % NV;
        exp_stolen = 1'b1;
      end
      base = 16'(16 * (v + 1));
      if (exp_stolen) begin exp_addr.push_back(base); exp_data.push_back(8'h00); end
      exp_addr.push_back(base + 16'd1); exp_data.push_back(incr);
      exp_addr.push_back(base + 16'd2); exp_data.push_back(wave);
      exp_addr.push_back(base + 16'd3); exp_data.push_back(pulse);
      exp_addr.push_back(base + 16'd4); exp_data.push_back(sus);
      exp_addr.push_back(base);         exp_data.push_back(8'h01);
      m_active[v] = 1'b1;
      m_key[v] = key;
    end else if (hit >= 0) begin
      base = 16'(16 * (hit + 1));
      exp_addr.push_back(base);
      exp_data.push_back(8'h00);
      m_active[hit] = 1'b0;
    end
    exp_cycles = 2 + 2 * exp_addr.size();
    for (int i = 0; i < NV; i++) exp_active[i] = m_active[i];
  endtask

  // Drives one event and records what the bus did until NoteReady returns.
  task automatic apply_event(input bit on, input logic [7:0] key, incr, wave, pulse, sus);
    int k;
    bit done;
    obs_addr.delete();
    obs_data.delete();
    obs_stolen = 1'b0;
    obs_stolen_extra = 1'b0;
    obs_hold_err = 1'b0;
    obs_decide_rw = 1'b0;
    obs_active = '0;
    obs_cycles = -1;
    for (int i = 0; i < 40 && NoteReady !== 1'b1; i++) @(negedge Clock);
    NoteOn = on; NoteKey = key; NoteIncr = incr; NoteWave = wave;
    NotePulse = pulse; NoteSustain = sus; NoteValid = 1'b1;
    @(posedge Clock);
    #1;
    NoteValid = 1'b0;
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge Clock);
      k++;
      if (k == 1) obs_decide_rw = BusReadWrite;
      if (k == 2) begin
        obs_stolen = Stolen;
        obs_active = VoiceActive;
      end else if (Stolen !== 1'b0) begin
        obs_stolen_extra = 1'b1;
      end
      if (BusReadWrite === 1'b1 && BusClock === 1'b1) begin
        obs_addr.push_back(BusAddress);
        obs_data.push_back(BusWriteData);
      end else if (BusReadWrite === 1'b1 && obs_addr.size() > 0) begin
        if (BusAddress !== obs_addr[$] || BusWriteData !== obs_data[$]) obs_hold_err = 1'b1;
      end
      if (NoteReady === 1'b1) begin
        obs_cycles = k;
        done = 1'b1;
        NoteValid = 1'b0;
      end else begin
        NoteValid = noise ? 1'($urandom) : 1'b0;
        NoteOn = 1'($urandom);
        NoteKey = 8'($urandom);
        NoteIncr = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    NoteValid = 1'b0; NoteOn = 1'b0; NoteKey = '0; NoteIncr = '0;
    NoteWave = '0; NotePulse = '0; NoteSustain = '0;
    model_reset();
    repeat (3) @(negedge Clock);
    checks++; if (NoteReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", NoteReady); end
    checks++; if (BusAddress !== 16'h0 || BusWriteData !== 8'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h/%h expected 0000/00", BusAddress, BusWriteData); end
    checks++; if (BusReadWrite !== 1'b0 || BusClock !== 1'b0 || Stolen !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl: got rw=%b clk=%b stolen=%b expected 0", BusReadWrite, BusClock, Stolen); end
    checks++; if (VoiceActive !== '0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0000", VoiceActive); end
    Reset = 1'b0;
    @(negedge Clock);
    checks++; if (NoteReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", NoteReady); end
  endtask

  task automatic test_fresh_note();
    model_event(1'b1, 8'd60, 8'h0F, 8'h01, 8'h3F, 8'h7F);
    apply_event(1'b1, 8'd60, 8'h0F, 8'h01, 8'h3F, 8'h7F);
    checks++; if (obs_cycles !== 12) begin errors++; $display("[TB] FAIL fresh_ready_cycle: got %0d expected 12", obs_cycles); end
    checks++; if (obs_addr.size() !== 5) begin errors++; $display("[TB] FAIL fresh_write_count: got %0d expected 5", obs_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("[TB] FAIL fresh_write%0d: got %h=%h expected %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++; if (obs_active !== 4'b0001) begin errors++; $display("[TB] FAIL fresh_active: got %b expected 0001", obs_active); end
    checks++; if (obs_stolen !== 1'b0) begin errors++; $display("[TB] FAIL fresh_stolen: got %b expected 0", obs_stolen); end
    checks++; if (obs_decide_rw !== 1'b0) begin errors++; $display("[TB] FAIL fresh_decide_rw: got %b expected 0", obs_decide_rw); end
  endtask

  task automatic test_steal();
    logic [7:0] ks [3] = '{8'd62, 8'd64, 8'd67};
    foreach (ks[i]) begin
      model_event(1'b1, ks[i], 8'(i), 8'h02, 8'h20, 8'h40);
      apply_event(1'b1, ks[i], 8'(i), 8'h02, 8'h20, 8'h40);
      checks++; if (obs_cycles !== exp_cycles) begin errors++; $display("[TB] FAIL fill%0d_ready_cycle: got %0d expected %0d", i, obs_cycles, exp_cycles); end
    end
    model_event(1'b1, 8'd69, 8'hA1, 8'h03, 8'h11, 8'h22);
    apply_event(1'b1, 8'd69, 8'hA1, 8'h03, 8'h11, 8'h22);
    checks++; if (obs_cycles !== 14) begin errors++; $display("[TB] FAIL steal_ready_cycle: got %0d expected 14", obs_cycles); end
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("[TB] FAIL steal_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
    checks++; if (obs_addr.size() < 1 || obs_addr[0] !== 16'h0010 || obs_data[0] !== 8'h00) begin errors++; $display("[TB] FAIL steal_first_write: expected 0010=00, got %0d writes", obs_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("[TB] FAIL steal_write%0d: got %h=%h expected %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++; if (obs_stolen !== 1'b1) begin errors++; $display("[TB] FAIL steal_stolen: got %b expected 1", obs_stolen); end
    checks++; if (obs_stolen_extra) begin errors++; $display("[TB] FAIL steal_stolen_width: got pulse longer than 1 cycle, expected 1 cycle"); end
    checks++; if (obs_active !== 4'b1111) begin errors++; $display("[TB] FAIL steal_active: got %b expected 1111", obs_active); end
  endtask

  task automatic test_note_off();
    model_event(1'b0, 8'd62, 8'h00, 8'h00, 8'h00, 8'h00);
    apply_event(1'b0, 8'd62, 8'h55, 8'h55, 8'h55, 8'h55);
    checks++; if (obs_cycles !== 4) begin errors++; $display("[TB] FAIL off_ready_cycle: got %0d expected 4", obs_cycles); end
    checks++; if (obs_addr.size() !== 1 || obs_addr[0] !== 16'h0020 || obs_data[0] !== 8'h00) begin errors++; $display("[TB] FAIL off_write: got %0d writes, expected one 0020=00", obs_addr.size()); end
    checks++; if (obs_active !== 4'b1101) begin errors++; $display("[TB] FAIL off_active: got %b expected 1101", obs_active); end
  endtask

  task automatic test_note_off_miss();
    model_event(1'b0, 8'd99, 8'h00, 8'h00, 8'h00, 8'h00);
    apply_event(1'b0, 8'd99, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++; if (obs_cycles !== 2) begin errors++; $display("[TB] FAIL miss_ready_cycle: got %0d expected 2", obs_cycles); end
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("[TB] FAIL miss_writes: got %0d expected 0", obs_addr.size()); end
    checks++; if (obs_active !== exp_active) begin errors++; $display("[TB] FAIL miss_active: got %b expected %b", obs_active, exp_active); end
  endtask

  task automatic test_retrigger();
    model_event(1'b1, 8'd69, 8'h33, 8'h04, 8'h44, 8'h66);
    apply_event(1'b1, 8'd69, 8'h33, 8'h04, 8'h44, 8'h66);
    checks++; if (obs_cycles !== 14) begin errors++; $display("[TB] FAIL retrig_ready_cycle: got %0d expected 14", obs_cycles); end
    checks++; if (obs_stolen !== 1'b1) begin errors++; $display("[TB] FAIL retrig_stolen: got %b expected 1", obs_stolen); end
    checks++; if (obs_addr.size() !== 6 || obs_addr[0] !== 16'h0010 || obs_addr[5] !== 16'h0010 || obs_data[5] !== 8'h01) begin errors++; $display("[TB] FAIL retrig_writes: got %0d writes, expected 0010=00 .. 0010=01", obs_addr.size()); end
    // Refill voice 1, then a steal must land on voice 1: the retrigger left the pointer alone.
    model_event(1'b1, 8'd72, 8'h01, 8'h01, 8'h01, 8'h01);
    apply_event(1'b1, 8'd72, 8'h01, 8'h01, 8'h01, 8'h01);
    checks++; if (obs_addr.size() < 1 || obs_addr[0] !== 16'h0021) begin errors++; $display("[TB] FAIL refill_first_write: got %0d writes, expected first at 0021", obs_addr.size()); end
    model_event(1'b1, 8'd73, 8'h02, 8'h02, 8'h02, 8'h02);
    apply_event(1'b1, 8'd73, 8'h02, 8'h02, 8'h02, 8'h02);
    checks++; if (obs_addr.size() < 1 || obs_addr[0] !== 16'h0020 || obs_stolen !== 1'b1) begin errors++; $display("[TB] FAIL next_steal_target: got %0d writes stolen=%b, expected first at 0020 stolen=1", obs_addr.size(), obs_stolen); end
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    @(negedge Clock);
    NoteOn = 1'b1; NoteKey = 8'd80; NoteIncr = 8'h11; NoteWave = 8'h22;
    NotePulse = 8'h33; NoteSustain = 8'h44; NoteValid = 1'b1;
    @(posedge Clock);
    #1;
    NoteValid = 1'b0;
    repeat (6) @(negedge Clock);
    checks++; if (BusClock !== 1'b1 || BusAddress !== 16'h0013 || BusWriteData !== 8'h33) begin errors++; $display("[TB] FAIL midreset_third_write: got clk=%b %h=%h expected clk=1 0013=33", BusClock, BusAddress, BusWriteData); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (BusClock !== 1'b0 || BusReadWrite !== 1'b0) begin errors++; $display("[TB] FAIL midreset_bus: got clk=%b rw=%b expected 0/0", BusClock, BusReadWrite); end
    checks++; if (VoiceActive !== '0 || NoteReady !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state: got active=%b ready=%b expected 0000/0", VoiceActive, NoteReady); end
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    #1;
    checks++; if (NoteReady !== 1'b1) begin errors++; $display("[TB] FAIL midreset_release_ready: got %b expected 1", NoteReady); end
    model_event(1'b1, 8'd81, 8'h05, 8'h06, 8'h07, 8'h08);
    apply_event(1'b1, 8'd81, 8'h05, 8'h06, 8'h07, 8'h08);
    checks++; if (obs_addr.size() !== 5 || obs_addr[0] !== 16'h0011 || obs_stolen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_next_note: got %0d writes stolen=%b, expected 5 writes from 0011", obs_addr.size(), obs_stolen); end
    checks++; if (obs_active !== 4'b0001) begin errors++; $display("[TB] FAIL midreset_active: got %b expected 0001", obs_active); end
  endtask

  task automatic test_random();
    bit on;
    logic [7:0] key, incr, wave, pulse, sus;
    noise = 1'b1;
    for (int n = 0; n < 60; n++) begin
      on = ($urandom_range(0, 99) < 65);
      key = 8'(60 + $urandom_range(0, 6));
      incr = 8'($urandom); wave = 8'($urandom); pulse = 8'($urandom); sus = 8'($urandom);
      model_event(on, key, incr, wave, pulse, sus);
      apply_event(on, key, incr, wave, pulse, sus);
      checks++; if (obs_cycles !== exp_cycles) begin errors++; $display("[TB] FAIL rnd%0d_ready_cycle: got %0d expected %0d", n, obs_cycles, exp_cycles); end
      checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("[TB] FAIL rnd%0d_write_count: got %0d expected %0d", n, obs_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          errors++; $display("[TB] FAIL rnd%0d_write%0d: got %h=%h expected %h=%h", n, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
      checks++; if (obs_stolen !== exp_stolen || obs_stolen_extra) begin errors++; $display("[TB] FAIL rnd%0d_stolen: got %b (extra=%0d) expected %b", n, obs_stolen, obs_stolen_extra, exp_stolen); end
      checks++; if (obs_active !== exp_active) begin errors++; $display("[TB] FAIL rnd%0d_active: got %b expected %b", n, obs_active, exp_active); end
      checks++; if (obs_hold_err || obs_decide_rw !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_strobe: got hold_err=%0d decide_rw=%b expected 0/0", n, obs_hold_err, obs_decide_rw); end
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fresh_note();
    test_steal();
    test_note_off();
    test_note_off_miss();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
